// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared state codes, error codes and default framing bytes for the UART command parser
package uart_cmd_pkg;
    localparam logic [2:0] ST_HUNT  = 3'd0;
    localparam logic [2:0] ST_CMD   = 3'd1;
    localparam logic [2:0] ST_LEN   = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_CHK   = 3'd4;
    localparam logic [2:0] ST_RESP0 = 3'd5;
    localparam logic [2:0] ST_RESP1 = 3'd6;
    localparam logic [7:0] ERR_CHK   = 8'h01;
    localparam logic [7:0] ERR_LEN   = 8'h02;
    localparam logic [7:0] ERR_TRUNC = 8'h03;
    localparam logic [7:0] DEF_SYNC = 8'hA5;
    localparam logic [7:0] DEF_ACK  = 8'h06;
    localparam logic [7:0] DEF_NAK  = 8'h15;
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return v + {7'd0, v != 8'hFF};
    endfunction
endpackage

// File: rtl/uart_byte_fetch.sv
// uart_byte_fetch: one-at-a-time RX FIFO pop handshake plus sticky end-of-burst flag
module uart_byte_fetch (
    input  logic clock,
    input  logic reset,
    input  logic rx_fifo_empty,
    input  logic fetch_en,
    input  logic end_strobe,
    input  logic end_clear,
    output logic rx_fifo_read_en,
    output logic byte_valid,
    output logic end_event
);
    logic end_flag;
    logic idle;
    assign idle = !rx_fifo_read_en && !byte_valid;
    assign end_event = end_flag && idle && rx_fifo_empty && fetch_en;
    // Pop when nothing is in flight; the end flag only fires once the FIFO is drained
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_fifo_read_en <= 1'b0;
            byte_valid <= 1'b0;
            end_flag <= 1'b0;
        end else begin
            rx_fifo_read_en <= idle && !rx_fifo_empty && fetch_en;
            byte_valid <= rx_fifo_read_en;
            end_flag <= (end_flag && !end_event && !end_clear) || end_strobe;
        end
    end
endmodule

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: frames SYNC/CMD/LEN/payload/CHK packets, strobes good commands, returns ACK/NAK
module uart_cmd_parser import uart_cmd_pkg::*; #(
    parameter int MAX_LEN = 8,
    parameter logic [7:0] SYNC_BYTE = DEF_SYNC,
    parameter logic [7:0] ACK_BYTE = DEF_ACK,
    parameter logic [7:0] NAK_BYTE = DEF_NAK
) (
    input  logic clock,
    input  logic reset,
    input  logic rx_fifo_empty,
    input  logic [7:0] rx_fifo_data_out,
    output logic rx_fifo_read_en,
    input  logic UartPacketReceived,
    input  logic tx_fifo_full,
    output logic [7:0] tx_fifo_data_in,
    output logic tx_fifo_write_en,
    output logic cmd_valid,
    output logic [7:0] cmd_code,
    output logic [4:0] cmd_len,
    output logic [MAX_LEN*8-1:0] cmd_payload,
    output logic [7:0] err_count
);
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    logic [2:0] state;
    logic [7:0] chk, code_q, resp_b0, resp_b1, nak_code;
    logic [4:0] len_q;
    logic [IW-1:0] idx;
    logic [7:0] pbuf [MAX_LEN];
    logic byte_valid, end_event, nak_en;
    assign nak_code = (byte_valid && state == ST_LEN && rx_fifo_data_out > 8'(MAX_LEN)) ? ERR_LEN :
                      (byte_valid && state == ST_CHK && rx_fifo_data_out != chk) ? ERR_CHK :
                      (end_event && state != ST_HUNT) ? ERR_TRUNC : 8'h00;
    assign nak_en = nak_code != 8'h00;
    uart_byte_fetch u_fetch (
        .clock(clock),
        .reset(reset),
        .rx_fifo_empty(rx_fifo_empty),
        .fetch_en(state <= ST_CHK),
        .end_strobe(UartPacketReceived),
        .end_clear(state == ST_RESP1 && !tx_fifo_full),
        .rx_fifo_read_en(rx_fifo_read_en),
        .byte_valid(byte_valid),
        .end_event(end_event)
    );
    // Payload capture buffer; bytes beyond LEN are masked when the command is published
    always_ff @(posedge clock) begin
        if (byte_valid && state == ST_DATA) pbuf[idx] <= rx_fifo_data_out;
    end
    // Frame state machine, command publication and response byte sequencing
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_HUNT;
            chk <= '0;
            code_q <= '0;
            len_q <= '0;
            idx <= '0;
            resp_b0 <= '0;
            resp_b1 <= '0;
            tx_fifo_data_in <= '0;
            tx_fifo_write_en <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_code <= '0;
            cmd_len <= '0;
            cmd_payload <= '0;
            err_count <= '0;
        end else begin
            cmd_valid <= 1'b0;
            tx_fifo_write_en <= 1'b0;
            if (nak_en) begin
                resp_b0 <= NAK_BYTE;
                resp_b1 <= nak_code;
                err_count <= sat_inc(err_count);
                state <= ST_RESP0;
            end else if (byte_valid) begin
                case (state)
                    ST_HUNT: if (rx_fifo_data_out == SYNC_BYTE) begin
                        state <= ST_CMD;
                        chk <= '0;
                    end
                    ST_CMD: begin
                        code_q <= rx_fifo_data_out;
                        chk <= chk ^ rx_fifo_data_out;
                        state <= ST_LEN;
                    end
                    ST_LEN: begin
                        chk <= chk ^ rx_fifo_data_out;
                        len_q <= rx_fifo_data_out[4:0];
                        idx <= '0;
                        state <= (rx_fifo_data_out == 8'h00) ? ST_CHK : ST_DATA;
                    end
                    ST_DATA: begin
                        chk <= chk ^ rx_fifo_data_out;
                        idx <= idx + 1'b1;
                        if (5'(idx) == len_q - 5'd1) state <= ST_CHK;
                    end
                    ST_CHK: begin
                        cmd_valid <= 1'b1;
                        cmd_code <= code_q;
                        cmd_len <= len_q;
                        for (int i = 0; i < MAX_LEN; i++)
                            cmd_payload[i*8 +: 8] <= (i < int'(len_q)) ? pbuf[i] : 8'h00;
                        resp_b0 <= ACK_BYTE;
                        resp_b1 <= code_q;
                        state <= ST_RESP0;
                    end
                    default: ;
                endcase
            end else if (state == ST_RESP0 && !tx_fifo_full) begin
                tx_fifo_write_en <= 1'b1;
                tx_fifo_data_in <= resp_b0;
                state <= ST_RESP1;
            end else if (state == ST_RESP1 && !tx_fifo_full) begin
                tx_fifo_write_en <= 1'b1;
                tx_fifo_data_in <= resp_b1;
                state <= ST_HUNT;
            end
        end
    end
endmodule
